// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, operand width and command record for the safe ALU path.
package alu_pkg;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_MOD = 3'b101;
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } cmd_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and an occupancy count one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands, drives the FIFO head to the ALU and registers tagged results with error accounting.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = alu_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_error,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_error,
  output logic [7:0]   out_seq,
  input  logic         err_clr,
  output logic         err_flag,
  output logic [7:0]   err_count
);
  cmd_t wr_cmd, head;
  logic full, empty, free, pop;
  logic [7:0] seq;
  assign wr_cmd = '{a: in_a, b: in_b, op: in_op};
  assign in_ready = !rst && !full;
  assign free = !out_valid || out_ready;
  assign pop = free && !empty;
  assign alu_a = empty ? '0 : head.a;
  assign alu_b = empty ? '0 : head.b;
  assign alu_op = empty ? '0 : head.op;
  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid && in_ready),
    .pop(pop),
    .wdata(wr_cmd),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_error <= 1'b0;
      out_seq <= '0;
      seq <= '0;
      err_flag <= 1'b0;
      err_count <= '0;
    end else begin
      if (free) out_valid <= !empty;
      if (pop) begin
        out_result <= alu_result;
        out_error <= alu_error;
        out_seq <= seq;
        seq <= seq + 8'd1;
      end
      // an errored capture outranks a same-cycle clear
      err_flag <= (pop && alu_error) || (err_flag && !err_clr);
      if (pop && alu_error && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream issue stage for the 8-bit safe ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the combinational ALU, then registers the ALU's result and error flag into an output stage with its own valid/ready handshake. It also keeps a saturating error count, a sticky error flag and a wrapping sequence tag, so downstream logic can match results to commands and monitor fault rate.

## Interface
- DEPTH, 4, command FIFO depth; power of two, at least 2
- W, 8, operand/result width; must match the ALU
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept a command
- in_a, in_b  in  W  operands
- in_op  in  3  opcode (ALU encoding)
- alu_a, alu_b  out  W  FIFO-head operands to ALU
- alu_op  out  3  FIFO-head opcode to ALU
- alu_result  in  W  ALU result
- alu_error  in  1  ALU error flag
- out_valid  out  1  registered result available
- out_ready  in  1  downstream accepts result
- out_result  out  W  captured result
- out_error  out  1  captured error flag
- out_seq  out  8  sequence tag of this result
- err_clr  in  1  clear sticky error flag
- err_flag  out  1  sticky: any error since reset/clear
- err_count  out  8  number of errored results, saturating

## Operation
- Push: a command is written to the FIFO tail when in_valid && in_ready. in_ready = (count < DEPTH); it does not depend on out_ready or on a same-cycle pop.
- ALU drive: when the FIFO is non-empty, alu_a/alu_b/alu_op show the head entry. When it is empty, they are all zero.
- Pop/capture: the stage is free when !out_valid || out_ready. When it is free and the FIFO is non-empty, on the clock edge:
  - pop the head;
  - out_result <= alu_result, out_error <= alu_error, out_valid <= 1;
  - out_seq <= internal seq counter, then the counter increments (8-bit, 255 wraps to 0).
- Stage free and FIFO empty: out_valid <= 0.
- Stall: while out_valid && !out_ready, out_* hold and no pop occurs.
- Push and pop in the same cycle leave count unchanged. This is legal at every count, including full: in_ready is already 0 when full, so a push is impossible then.
- Error accounting happens on a capture with alu_error = 1:
  - err_count increments and saturates at 255;
  - err_flag sets.
- err_clr clears err_flag only; err_count is never cleared except by reset.
- err_clr in the same cycle as an errored capture: the set wins, so err_flag = 1.
- Opcodes are passed through unchanged. Illegal opcodes (110/111) and divide/mod by zero are flagged by the ALU; the sequencer only counts them.
- Data order is strict FIFO; no reordering or dropping.

## Timing
- Reset values: in_ready = 0 while rst is high, then 1 in the first cycle after. out_valid, out_result, out_error, out_seq, err_flag and err_count are all 0. The FIFO is empty, the seq counter is 0, and alu_a/alu_b/alu_op are 0.
- rst asserted mid-operation discards all FIFO contents and any pending output, even if out_valid && !out_ready.
- Latency: a command accepted at edge k is at the FIFO head in cycle k+1 and is captured at edge k+1. out_valid is therefore high in cycle k+2 at minimum, i.e. 2 cycles.
- Throughput: 1 result per cycle while out_ready is held high and the input is streaming.
- Capacity: DEPTH commands in the FIFO plus 1 in the output stage.
- All outputs are registered except in_ready and alu_a/alu_b/alu_op, which decode from registered state only.

## Structure
- Package alu_pkg holds:
  - opcode constants OP_ADD = 000, OP_SUB = 001, OP_AND = 010, OP_OR = 011, OP_DIV = 100, OP_MOD = 101;
  - the operand width constant W = 8;
  - the command struct {a, b, op}.
- Sub-module sync_fifo provides the command buffer. It is parameterised by width and depth, uses pointer wrap with a count of width clog2(DEPTH)+1, and has push/pop/full/empty ports.
- Output stage, seq counter and error accounting live in the top level.

## Test plan
- Reset then single ADD: a=8'd20, b=8'd22, op=000 accepted at edge 0 -> cycle 2: out_valid=1, out_result=42, out_error=0, out_seq=0.
- Backpressure fill: out_ready=0, push 6 commands -> 5 accepted (4 in FIFO + 1 in output), in_ready=0 after the 5th. Release out_ready -> results emerge in order with seq 0..4 and no loss.
- Divide by zero: a=8'd9, b=0, op=100 -> out_error=1, out_result=0, err_flag=1, err_count=1. Next a=8'd9, b=8'd2, op=101 -> out_result=1, out_error=0, err_count remains 1.
- Clear contention: err_clr=1 in the same cycle as an errored capture (op=111) -> err_flag=1. err_clr alone the next cycle -> err_flag=0, err_count unchanged.
- Saturation/wrap: 300 back-to-back op=110 commands -> err_count=255 stays; out_seq wraps 255 -> 0 at the 257th result.
- Mid-stream reset: 3 queued, out_valid=1 stalled, rst pulsed for 1 cycle -> out_valid=0, FIFO empty, next command gets out_seq=0.
